// File: rtl/sap_run_ctrl.sv
// sap_run_ctrl: loads a program over a valid/ready byte port with the core held in reset, then
// gates the core clock enable for run/pause/step and stops on low_halt. Macro: LOAD_CHECKSUM_EN.
module sap_run_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int STEP_CYCLES = 6
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              stop_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              host_last_i,
  input  logic              low_halt_i,
  output logic              cpu_en_o,
  output logic              cpu_clr_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
`ifdef LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] load_sum_o,
`endif
  output logic [2:0]        state_o,
  output logic [7:0]        instr_count_o
);

  localparam int PH_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_STEP   = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q;
  logic [7:0]        instr_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  logic core_en, core_clr, accept, wrap, last_addr, load_entry;

  assign core_en    = (state_q == S_RUN) || (state_q == S_STEP);
  assign core_clr   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = host_valid_i && (state_q == S_LOAD);
  assign wrap       = core_en && (phase_q == PH_LAST);
  assign last_addr  = (wr_ptr_q == {ADDR_W{1'b1}});
  assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_i)       state_d = S_LOAD;
        else if (start_i) state_d = S_RUN;
        else if (step_i)  state_d = S_STEP;
      end
      S_LOAD: begin
        // Loading never wraps: the top address ends the load even without host_last.
        if (accept && (host_last_i || last_addr)) state_d = S_IDLE;
      end
      S_RUN: begin
        if (!low_halt_i)  state_d = S_HALTED;
        else if (stop_i)  state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (load_i)       state_d = S_LOAD;
        else if (start_i) state_d = S_RUN;
        else if (step_i)  state_d = S_STEP;
      end
      S_STEP: begin
        if (!low_halt_i)            state_d = S_HALTED;
        else if (stop_i || wrap)    state_d = S_PAUSED;
      end
      S_HALTED: begin
        if (load_i)       state_d = S_LOAD;
      end
      default:            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      instr_q    <= '0;
      wr_ptr_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q <= state_d;
      // Phase mirrors the core ring counter, so it only moves when the core is enabled.
      if (core_clr) begin
        phase_q <= '0;
        instr_q <= '0;
      end else if (core_en) begin
        phase_q <= wrap ? '0 : phase_q + PH_W'(1);
        if (wrap) instr_q <= instr_q + 8'd1;
      end
      ram_we_q <= accept;
      if (accept) begin
        ram_addr_q <= wr_ptr_q;
        ram_data_q <= host_data_i;
        wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
      end else if (load_entry) begin
        ram_addr_q <= '0;
        wr_ptr_q   <= '0;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum_q;

  always_ff @(posedge clk_i) begin
    if (clr_i || load_entry) load_sum_q <= '0;
    else if (accept)         load_sum_q <= load_sum_q + host_data_i;
  end

  assign load_sum_o = load_sum_q;
`endif

  assign host_ready_o  = (state_q == S_LOAD);
  assign cpu_en_o      = core_en;
  assign cpu_clr_o     = core_clr;
  assign ram_we_o      = ram_we_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_data_o    = ram_data_q;
  assign state_o       = state_q;
  assign instr_count_o = instr_q;

endmodule

// File: tb/tb_sap_run_ctrl.sv
// Bench for sap_run_ctrl: vector table, directed corner sequences, then random stimulus vs model.
module tb_sap_run_ctrl;
  localparam int S     = 6;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       clr, load, start, step, stop, hv, hl, hn;
  logic [7:0] hd;
  logic       hr, cpu_en, cpu_clr, we;
  logic [3:0] addr;
  logic [7:0] wdat, ic;
  logic [2:0] dut_state;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] load_sum;
`endif

  int n_chk = 0;
  int n_fail = 0;

  sap_run_ctrl dut (
    .clk_i(clk), .clr_i(clr), .load_i(load), .start_i(start), .step_i(step), .stop_i(stop),
    .host_valid_i(hv), .host_ready_o(hr), .host_data_i(hd), .host_last_i(hl),
    .low_halt_i(hn), .cpu_en_o(cpu_en), .cpu_clr_o(cpu_clr), .ram_we_o(we),
    .ram_addr_o(addr), .ram_data_o(wdat),
`ifdef LOAD_CHECKSUM_EN
    .load_sum_o(load_sum),
`endif
    .state_o(dut_state), .instr_count_o(ic)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ld, st, sp, so, v, l, hn;
    logic [7:0] d;
    int   es;
    logic ew;
    int   ea, ed;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mkv(input logic a_ld, a_st, a_sp, a_so, a_v, a_l, a_hn,
                               input logic [7:0] a_d, input int a_es, input logic a_ew,
                               input int a_ea, input int a_ed);
    vec_t r;
    r.ld = a_ld; r.st = a_st; r.sp = a_sp; r.so = a_so; r.v = a_v; r.l = a_l; r.hn = a_hn;
    r.d = a_d; r.es = a_es; r.ew = a_ew; r.ea = a_ea; r.ed = a_ed;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_ld, a_st, a_sp, a_so, a_v, a_l, a_hn, input logic [7:0] a_d);
    load = a_ld; start = a_st; step = a_sp; stop = a_so;
    hv = a_v; hl = a_l; hn = a_hn; hd = a_d;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic do_clr();
    idle_in();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Decoded outputs follow directly from the externally visible state number.
  task automatic chk_state(input string p, input int es);
    chk({p, ".state"}, dut_state, es);
    chk({p, ".cpu_en"}, cpu_en, (es == 2 || es == 4) ? 1 : 0);
    chk({p, ".cpu_clr"}, cpu_clr, (es <= 1) ? 1 : 0);
    chk({p, ".host_ready"}, hr, (es == 1) ? 1 : 0);
  endtask

  // Reference model: mode number, total enabled cycles since core clear, load pointer.
  int m_mode, m_ticks, m_ptr, m_addr, m_data, m_sum;
  bit m_we;

  task automatic model_reset();
    m_mode = 0; m_ticks = 0; m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_sum = 0;
  endtask

  task automatic model_step(input logic a_ld, a_st, a_sp, a_so, a_v, a_l, a_hn,
                            input logic [7:0] a_d);
    int  nm;
    bit  running, acc;
    running = (m_mode == 2 || m_mode == 4);
    acc = (m_mode == 1) && a_v;
    nm = m_mode;
    if (running && !a_hn)                                nm = 5;
    else if (a_ld && (m_mode == 0 || m_mode == 3 || m_mode == 5)) nm = 1;
    else if (a_so && running)                            nm = 3;
    else if (a_st && (m_mode == 0 || m_mode == 3))       nm = 2;
    else if (a_sp && (m_mode == 0 || m_mode == 3))       nm = 4;
    else if (m_mode == 4 && (m_ticks % S) == S - 1)      nm = 3;
    else if (acc && (a_l || m_ptr == DEPTH - 1))         nm = 0;
    if (m_mode <= 1) m_ticks = 0;
    else if (running) m_ticks++;
    m_we = acc;
    if (acc) begin
      m_addr = m_ptr; m_data = a_d; m_ptr++; m_sum = (m_sum + a_d) % 256;
    end
    if (nm == 1 && m_mode != 1) begin
      m_ptr = 0; m_sum = 0;
    end
    m_mode = nm;
  endtask

  initial begin
    int cnt;
    clr = 1'b0;
    idle_in();

    // Reset state
    do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
    chk_state("reset", 0);
    chk("reset.ram_we", we, 0);
    chk("reset.ram_addr", addr, 0);
    chk("reset.ram_data", wdat, 0);
    chk("reset.instr", ic, 0);
    do_clr();

    //            ld st sp so v  l  hn data   state we addr data
    vt[0]  = mkv(1, 0, 0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    vt[1]  = mkv(0, 0, 0, 0, 1, 0, 1, 8'h1E, 1, 1, 0, 8'h1E);
    vt[2]  = mkv(0, 0, 0, 0, 1, 0, 1, 8'h2F, 1, 1, 1, 8'h2F);
    vt[3]  = mkv(0, 0, 0, 0, 1, 0, 1, 8'hE0, 1, 1, 2, 8'hE0);
    vt[4]  = mkv(0, 0, 0, 0, 1, 1, 1, 8'hF0, 0, 1, 3, 8'hF0);
    vt[5]  = mkv(0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
    vt[6]  = mkv(1, 1, 0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    vt[7]  = mkv(0, 1, 1, 1, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    vt[8]  = mkv(0, 0, 0, 0, 1, 0, 1, 8'hAA, 1, 1, 0, 8'hAA);
    vt[9]  = mkv(0, 0, 0, 0, 1, 1, 1, 8'h55, 0, 1, 1, 8'h55);
    vt[10] = mkv(0, 1, 0, 0, 0, 0, 1, 8'h00, 2, 0, 0, 0);
    vt[11] = mkv(0, 1, 0, 1, 0, 0, 1, 8'h00, 3, 0, 0, 0);
    vt[12] = mkv(0, 1, 1, 0, 0, 0, 1, 8'h00, 2, 0, 0, 0);
    vt[13] = mkv(0, 0, 0, 1, 0, 0, 1, 8'h00, 3, 0, 0, 0);
    vt[14] = mkv(0, 0, 1, 0, 0, 0, 1, 8'h00, 4, 0, 0, 0);
    vt[15] = mkv(0, 0, 0, 1, 0, 0, 1, 8'h00, 3, 0, 0, 0);
    vt[16] = mkv(1, 0, 0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    vt[17] = mkv(0, 0, 0, 0, 1, 1, 1, 8'h01, 0, 1, 0, 8'h01);
    vt[18] = mkv(0, 0, 1, 0, 0, 0, 1, 8'h00, 4, 0, 0, 0);
    vt[19] = mkv(0, 0, 0, 0, 0, 0, 0, 8'h00, 5, 0, 0, 0);
    vt[20] = mkv(0, 1, 0, 0, 0, 0, 1, 8'h00, 5, 0, 0, 0);
    vt[21] = mkv(0, 0, 1, 0, 0, 0, 1, 8'h00, 5, 0, 0, 0);
    vt[22] = mkv(1, 0, 0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    vt[23] = mkv(0, 0, 0, 0, 1, 1, 1, 8'h77, 0, 1, 0, 8'h77);

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].ld, vt[i].st, vt[i].sp, vt[i].so, vt[i].v, vt[i].l, vt[i].hn, vt[i].d);
      tick();
      chk_state($sformatf("vec%0d", i), vt[i].es);
      chk($sformatf("vec%0d.ram_we", i), we, vt[i].ew);
      if (vt[i].ew) begin
        chk($sformatf("vec%0d.ram_addr", i), addr, vt[i].ea);
        chk($sformatf("vec%0d.ram_data", i), wdat, vt[i].ed);
      end
    end

    // Full-depth load without host_last stops at the top address
    do_clr();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h00); tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 0, 1, 8'(i * 17 + 3)); tick();
      chk($sformatf("full%0d.ram_we", i), we, 1);
      chk($sformatf("full%0d.ram_addr", i), addr, i);
      chk($sformatf("full%0d.ram_data", i), wdat, (i * 17 + 3) % 256);
    end
    chk_state("full.end", 0);
    drive(0, 0, 0, 0, 1, 0, 1, 8'h99); tick();
    chk("full.extra_we", we, 0);
    chk_state("full.extra", 0);

    // Halt in the third instruction, 15 enabled cycles in
    do_clr();
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00); tick();
    chk_state("halt.run", 2);
    idle_in();
    for (int i = 0; i < 14; i++) tick();
    chk("halt.pre_instr", ic, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00); tick();
    chk_state("halt", 5);
    chk("halt.instr", ic, 2);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00); tick();
    chk_state("halt.start_ign", 5);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h00); tick();
    chk_state("halt.step_ign", 5);
    chk("halt.instr_hold", ic, 2);

    // Pause at phase 2, then step finishes the instruction in 4 enabled cycles
    do_clr();
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00); tick();
    idle_in(); tick();
    drive(0, 0, 0, 1, 0, 0, 1, 8'h00); tick();
    chk_state("step.paused", 3);
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      drive(0, 0, 1, 0, 0, 0, 1, 8'h00); tick();
      if (cpu_en) cnt++;
      idle_in();
      for (int i = 0; i < 20 && dut_state != 3; i++) begin
        tick();
        if (cpu_en) cnt++;
      end
      chk($sformatf("step%0d.en_cycles", k), cnt, (k == 0) ? 4 : S);
      chk_state($sformatf("step%0d.end", k), 3);
      chk($sformatf("step%0d.instr", k), ic, k + 1);
    end

    // Reset aborts a load in progress
    do_clr();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h00); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 1, 8'(i + 1)); tick();
    end
    clr = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 1, 8'h44); tick();
    clr = 1'b0;
    chk_state("abort", 0);
    chk("abort.ram_we", we, 0);

`ifdef LOAD_CHECKSUM_EN
    do_clr();
    drive(1, 0, 0, 0, 0, 0, 1, 8'h00); tick();
    drive(0, 0, 0, 0, 1, 0, 1, 8'hFF); tick();
    drive(0, 0, 0, 0, 1, 1, 1, 8'h02); tick();
    idle_in(); tick();
    chk("sum.first", load_sum, 8'h01);
    drive(1, 0, 0, 0, 0, 0, 1, 8'h00); tick();
    drive(0, 0, 0, 0, 1, 1, 1, 8'h10); tick();
    idle_in(); tick();
    chk("sum.second", load_sum, 8'h10);
`endif

    // Randomized run against the reference model
    do_clr();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r_ld, r_st, r_sp, r_so, r_v, r_l, r_hn;
      logic [7:0] r_d;
      r_ld = ($urandom_range(0, 99) < 4);
      r_st = ($urandom_range(0, 99) < 8);
      r_sp = ($urandom_range(0, 99) < 8);
      r_so = ($urandom_range(0, 99) < 6);
      r_v  = ($urandom_range(0, 99) < 50);
      r_l  = ($urandom_range(0, 99) < 10);
      r_hn = ($urandom_range(0, 99) >= 2);
      r_d  = 8'($urandom);
      drive(r_ld, r_st, r_sp, r_so, r_v, r_l, r_hn, r_d);
      clr = ($urandom_range(0, 299) == 0);
      if (clr) model_reset();
      else model_step(r_ld, r_st, r_sp, r_so, r_v, r_l, r_hn, r_d);
      tick();
      clr = 1'b0;
      chk_state($sformatf("rnd%0d", c), m_mode);
      chk($sformatf("rnd%0d.ram_we", c), we, m_we);
      chk($sformatf("rnd%0d.instr", c), ic, (m_ticks / S) % 256);
      if (m_we) begin
        chk($sformatf("rnd%0d.ram_addr", c), addr, m_addr);
        chk($sformatf("rnd%0d.ram_data", c), wdat, m_data);
      end
`ifdef LOAD_CHECKSUM_EN
      chk($sformatf("rnd%0d.load_sum", c), load_sum, m_sum);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
